// File: rtl/m72_pkg.sv
// Shared palette constants, component/FSM types and pixel helpers
// for the palette mixer slice.
package m72_pkg;

   localparam int PAL_ENTRIES   = 256;
   localparam int PAL_COMP_BITS = 5;
   localparam int PAL_ADDR_BITS = $clog2(PAL_ENTRIES);
   localparam logic [9:0] CLEAR_LAST = 10'd767;

   typedef enum logic [1:0] {
      COMP_R    = 2'd0,
      COMP_G    = 2'd1,
      COMP_B    = 2'd2,
      COMP_NONE = 2'd3
   } comp_e;

   typedef enum logic {
      ST_CLEAR = 1'b0,
      ST_RUN   = 1'b1
   } clr_state_e;

   // Index nibble zero marks a transparent pixel.
   function automatic logic pix_opaque(input logic [7:0] pix);
      return (pix[3:0] != 4'd0);
   endfunction

endpackage

// File: rtl/palette_mixer_if.sv
// CPU palette access bus: address, write data, strobes, selects and read-back.
interface palette_mixer_if;
   logic [19:0] A;
   logic [15:0] DIN;
   logic [15:0] DOUT;
   logic        DOUT_VALID;
   logic [1:0]  BYTE_SEL;
   logic        MRD;
   logic        MWR;
   logic        CS_OBJPAL;
   logic        CS_BGPAL;

   modport master (
      output A, DIN, BYTE_SEL, MRD, MWR, CS_OBJPAL, CS_BGPAL,
      input  DOUT, DOUT_VALID
   );

   modport slave (
      input  A, DIN, BYTE_SEL, MRD, MWR, CS_OBJPAL, CS_BGPAL,
      output DOUT, DOUT_VALID
   );
endinterface

// File: rtl/dpramv.sv
// Dual-port RAM: port A synchronous write and registered read,
// port B asynchronous read so a same-edge write is seen one cycle later.
module dpramv #(
   parameter int WIDTH = 5,
   parameter int DEPTH = 256,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic             clk_i,
   input  logic             we_a_i,
   input  logic [AW-1:0]    addr_a_i,
   input  logic [WIDTH-1:0] d_a_i,
   output logic [WIDTH-1:0] q_a_o,
   input  logic [AW-1:0]    addr_b_i,
   output logic [WIDTH-1:0] q_b_o
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [WIDTH-1:0] q_a_q;

   // Port A write and registered read.
   always_ff @(posedge clk_i) begin
      if (we_a_i) begin
         mem_q[addr_a_i] <= d_a_i;
      end
      q_a_q <= mem_q[addr_a_i];
   end

   assign q_a_o = q_a_q;
   assign q_b_o = mem_q[addr_b_i];

endmodule

// File: rtl/palette_bank.sv
// One palette: R/G/B component RAMs with component-steered port A
// and a parallel RGB fetch on port B.
module palette_bank
   import m72_pkg::*;
(
   input  logic                     clk_i,
   input  logic                     we_i,
   input  comp_e                    comp_i,
   input  logic [PAL_ADDR_BITS-1:0] addr_a_i,
   input  logic [PAL_COMP_BITS-1:0] din_a_i,
   output logic [PAL_COMP_BITS-1:0] dout_a_o,
   input  logic [PAL_ADDR_BITS-1:0] addr_b_i,
   output logic [PAL_COMP_BITS-1:0] r_b_o,
   output logic [PAL_COMP_BITS-1:0] g_b_o,
   output logic [PAL_COMP_BITS-1:0] b_b_o
);

   logic [2:0]               we_s;
   logic [PAL_COMP_BITS-1:0] q_a_s [3];
   logic [PAL_COMP_BITS-1:0] q_b_s [3];
   comp_e                    comp_q;

   // Steer the write strobe to one component RAM; component 3 writes nothing.
   always_comb begin
      we_s = 3'b000;
      case (comp_i)
         COMP_R:  we_s = {2'b00, we_i};
         COMP_G:  we_s = {1'b0, we_i, 1'b0};
         COMP_B:  we_s = {we_i, 2'b00};
         default: we_s = 3'b000;
      endcase
   end

   for (genvar c = 0; c < 3; c++) begin : g_comp
      dpramv #(
         .WIDTH (PAL_COMP_BITS),
         .DEPTH (PAL_ENTRIES)
      ) u_ram (
         .clk_i    (clk_i),
         .we_a_i   (we_s[c]),
         .addr_a_i (addr_a_i),
         .d_a_i    (din_a_i),
         .q_a_o    (q_a_s[c]),
         .addr_b_i (addr_b_i),
         .q_b_o    (q_b_s[c])
      );
   end

   // Component select aligned with the registered RAM read.
   always_ff @(posedge clk_i) begin
      comp_q <= comp_i;
   end

   // Read-back mux; component 3 reads as zero.
   always_comb begin
      dout_a_o = 5'd0;
      case (comp_q)
         COMP_R:  dout_a_o = q_a_s[0];
         COMP_G:  dout_a_o = q_a_s[1];
         COMP_B:  dout_a_o = q_a_s[2];
         default: dout_a_o = 5'd0;
      endcase
   end

   assign r_b_o = q_b_s[0];
   assign g_b_o = q_b_s[1];
   assign b_b_o = q_b_s[2];

endmodule

// File: rtl/palette_mixer.sv
// Sprite/tile palette mixer: CPU-accessible OBJ and BG palettes, power-up
// clear sequencer and a two-stage CE_PIX colour lookup pipeline.
module palette_mixer
   import m72_pkg::*;
(
   input  logic                     CLK_32M,
   input  logic                     RESET,
   input  logic                     CE_PIX,
   palette_mixer_if.slave           cpu,
   input  logic [7:0]               OBJ_PIX,
   input  logic [7:0]               BG_PIX,
   input  logic                     BG_PRIO,
   input  logic                     HBLK,
   input  logic                     VBLK,
   output logic [PAL_COMP_BITS-1:0] R,
   output logic [PAL_COMP_BITS-1:0] G,
   output logic [PAL_COMP_BITS-1:0] B,
   output logic                     BUSY
);

   clr_state_e state_q;
   logic [9:0] cnt_q;
   logic       busy_q;

   comp_e                    cpu_comp_s;
   logic                     wr_ok_s;
   comp_e                    pa_comp_s;
   logic [PAL_ADDR_BITS-1:0] pa_addr_s;
   logic [PAL_COMP_BITS-1:0] pa_din_s;
   logic                     obj_we_s;
   logic                     bg_we_s;

   logic [PAL_COMP_BITS-1:0] obj_dout_s, bg_dout_s, rd_data_s;
   logic [PAL_COMP_BITS-1:0] obj_r_s, obj_g_s, obj_b_s;
   logic [PAL_COMP_BITS-1:0] bg_r_s, bg_g_s, bg_b_s;
   logic                     rd_obj_q, rd_bg_q, rd_zero_q;

   logic                     sel_bg_s;
   logic [7:0]               idx_s;
   logic                     sel_bg_q, blank_q;
   logic [7:0]               idx_q;
   logic [14:0]              pix_rgb_d;
   logic [14:0]              rgb_q;

   logic                     unused_s;
   assign unused_s = ^{cpu.A[19:11], cpu.A[0], cpu.DIN[15:5], cpu.BYTE_SEL[1]};

   // Clear sequencer: walks all 768 component entries once after reset.
   always_ff @(posedge CLK_32M or posedge RESET) begin
      if (RESET) begin
         state_q <= ST_CLEAR;
         cnt_q   <= 10'd0;
         busy_q  <= 1'b1;
      end else begin
         case (state_q)
            ST_CLEAR: begin
               if (cnt_q == CLEAR_LAST) begin
                  state_q <= ST_RUN;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 10'd1;
               end
            end
            ST_RUN: begin
               state_q <= ST_RUN;
               busy_q  <= 1'b0;
            end
            default: begin
               state_q <= ST_CLEAR;
               cnt_q   <= 10'd0;
               busy_q  <= 1'b1;
            end
         endcase
      end
   end

   assign cpu_comp_s = comp_e'(cpu.A[10:9]);
   assign wr_ok_s    = cpu.MWR & cpu.BYTE_SEL[0] & (cpu.CS_OBJPAL ^ cpu.CS_BGPAL)
                       & (cpu_comp_s != COMP_NONE) & ~busy_q;

   // Port A owner: clear counter while busy, otherwise the CPU.
   always_comb begin
      pa_comp_s = cpu_comp_s;
      pa_addr_s = cpu.A[8:1];
      pa_din_s  = cpu.DIN[4:0];
      obj_we_s  = 1'b0;
      bg_we_s   = 1'b0;
      if (state_q == ST_CLEAR) begin
         pa_comp_s = comp_e'(cnt_q[9:8]);
         pa_addr_s = cnt_q[7:0];
         pa_din_s  = 5'd0;
         obj_we_s  = 1'b1;
         bg_we_s   = 1'b1;
      end else begin
         obj_we_s  = wr_ok_s & cpu.CS_OBJPAL;
         bg_we_s   = wr_ok_s & cpu.CS_BGPAL;
      end
   end

   palette_bank u_obj (
      .clk_i    (CLK_32M),
      .we_i     (obj_we_s),
      .comp_i   (pa_comp_s),
      .addr_a_i (pa_addr_s),
      .din_a_i  (pa_din_s),
      .dout_a_o (obj_dout_s),
      .addr_b_i (idx_q),
      .r_b_o    (obj_r_s),
      .g_b_o    (obj_g_s),
      .b_b_o    (obj_b_s)
   );

   palette_bank u_bg (
      .clk_i    (CLK_32M),
      .we_i     (bg_we_s),
      .comp_i   (pa_comp_s),
      .addr_a_i (pa_addr_s),
      .din_a_i  (pa_din_s),
      .dout_a_o (bg_dout_s),
      .addr_b_i (idx_q),
      .r_b_o    (bg_r_s),
      .g_b_o    (bg_g_s),
      .b_b_o    (bg_b_s)
   );

   // Read-back qualifiers aligned with the registered RAM read.
   always_ff @(posedge CLK_32M or posedge RESET) begin
      if (RESET) begin
         rd_obj_q  <= 1'b0;
         rd_bg_q   <= 1'b0;
         rd_zero_q <= 1'b1;
      end else begin
         rd_obj_q  <= cpu.CS_OBJPAL & ~cpu.CS_BGPAL;
         rd_bg_q   <= cpu.CS_BGPAL & ~cpu.CS_OBJPAL;
         rd_zero_q <= busy_q;
      end
   end

   // CPU read data select.
   always_comb begin
      rd_data_s = 5'd0;
      if (rd_zero_q) begin
         rd_data_s = 5'd0;
      end else if (rd_obj_q) begin
         rd_data_s = obj_dout_s;
      end else if (rd_bg_q) begin
         rd_data_s = bg_dout_s;
      end else begin
         rd_data_s = 5'd0;
      end
   end

   assign cpu.DOUT       = {11'd0, rd_data_s};
   assign cpu.DOUT_VALID = cpu.MRD & (cpu.CS_OBJPAL | cpu.CS_BGPAL);

   // Priority: opaque tile with priority wins, else any opaque sprite wins.
   always_comb begin
      sel_bg_s  = (pix_opaque(BG_PIX) & BG_PRIO) | ~pix_opaque(OBJ_PIX);
      idx_s     = OBJ_PIX;
      pix_rgb_d = 15'd0;
      if (sel_bg_s) begin
         idx_s = BG_PIX;
      end else begin
         idx_s = OBJ_PIX;
      end
      if (blank_q) begin
         pix_rgb_d = 15'd0;
      end else if (sel_bg_q) begin
         pix_rgb_d = {bg_r_s, bg_g_s, bg_b_s};
      end else begin
         pix_rgb_d = {obj_r_s, obj_g_s, obj_b_s};
      end
   end

   // Two-stage pixel pipeline; the output stage is held black while clearing.
   always_ff @(posedge CLK_32M or posedge RESET) begin
      if (RESET) begin
         sel_bg_q <= 1'b0;
         idx_q    <= 8'd0;
         blank_q  <= 1'b0;
         rgb_q    <= 15'd0;
      end else begin
         if (CE_PIX) begin
            sel_bg_q <= sel_bg_s;
            idx_q    <= idx_s;
            blank_q  <= HBLK | VBLK;
         end
         if (state_q == ST_CLEAR) begin
            rgb_q <= 15'd0;
         end else if (CE_PIX) begin
            rgb_q <= pix_rgb_d;
         end
      end
   end

   assign R    = rgb_q[14:10];
   assign G    = rgb_q[9:5];
   assign B    = rgb_q[4:0];
   assign BUSY = busy_q;

endmodule

// File: tb/tb_palette_mixer.sv
// Directed self-checking bench for palette_mixer: clear timing, CPU access,
// priority mixing, blanking, CE hold and reset restart.
module tb_palette_mixer;

   logic       CLK_32M = 1'b0;
   logic       RESET   = 1'b1;
   logic       CE_PIX  = 1'b0;
   logic [7:0] OBJ_PIX = 8'd0;
   logic [7:0] BG_PIX  = 8'd0;
   logic       BG_PRIO = 1'b0;
   logic       HBLK    = 1'b0;
   logic       VBLK    = 1'b0;
   logic [4:0] R, G, B;
   logic       BUSY;

   int n_total = 0;
   int n_bad   = 0;

   localparam logic [14:0] OBJ_RGB = {5'h03, 5'h1F, 5'h0C};
   localparam logic [14:0] BG_RGB  = {5'h11, 5'h05, 5'h1A};

   palette_mixer_if bus ();

   palette_mixer dut (
      .CLK_32M (CLK_32M),
      .RESET   (RESET),
      .CE_PIX  (CE_PIX),
      .cpu     (bus.slave),
      .OBJ_PIX (OBJ_PIX),
      .BG_PIX  (BG_PIX),
      .BG_PRIO (BG_PRIO),
      .HBLK    (HBLK),
      .VBLK    (VBLK),
      .R       (R),
      .G       (G),
      .B       (B),
      .BUSY    (BUSY)
   );

   always #5 CLK_32M = ~CLK_32M;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic bus_idle();
      bus.A = 20'd0; bus.DIN = 16'd0; bus.BYTE_SEL = 2'b00;
      bus.MRD = 1'b0; bus.MWR = 1'b0; bus.CS_OBJPAL = 1'b0; bus.CS_BGPAL = 1'b0;
   endtask

   task automatic bus_drive_wr(input logic obj, input logic bg, input logic [1:0] comp,
                               input logic [7:0] entry, input logic [15:0] data);
      bus.A = {9'd0, comp, entry, 1'b0}; bus.DIN = data; bus.BYTE_SEL = 2'b01;
      bus.MWR = 1'b1; bus.MRD = 1'b0; bus.CS_OBJPAL = obj; bus.CS_BGPAL = bg;
   endtask

   task automatic cpu_write(input logic obj, input logic bg, input logic [1:0] comp,
                            input logic [7:0] entry, input logic [15:0] data);
      bus_drive_wr(obj, bg, comp, entry, data);
      @(negedge CLK_32M);
      bus_idle();
   endtask

   task automatic cpu_read(input logic obj, input logic bg, input logic [1:0] comp,
                           input logic [7:0] entry, output logic [15:0] data);
      bus.A = {9'd0, comp, entry, 1'b0}; bus.BYTE_SEL = 2'b01;
      bus.MRD = 1'b1; bus.MWR = 1'b0; bus.CS_OBJPAL = obj; bus.CS_BGPAL = bg;
      @(negedge CLK_32M);
      data = bus.DOUT;
      bus_idle();
   endtask

   task automatic ce_pulse();
      CE_PIX = 1'b1;
      @(negedge CLK_32M);
      CE_PIX = 1'b0;
   endtask

   task automatic set_pix(input logic [7:0] obj, input logic [7:0] bg, input logic prio,
                          input logic hb);
      OBJ_PIX = obj; BG_PIX = bg; BG_PRIO = prio; HBLK = hb;
   endtask

   initial begin
      logic [15:0] rd;
      int          n;
      bus_idle();
      repeat (3) @(negedge CLK_32M);
      check_val("rst_busy", {31'd0, BUSY}, 32'd1);
      check_val("rst_rgb", {17'd0, R, G, B}, 32'd0);

      // Clear length, with a write attempted mid-clear to an already cleared entry.
      RESET = 1'b0;
      n = 0;
      while (BUSY === 1'b1 && n < 2000) begin
         if (n == 100) bus_drive_wr(1'b1, 1'b0, 2'd0, 8'h10, 16'h001F);
         else bus_idle();
         n++;
         @(negedge CLK_32M);
      end
      bus_idle();
      check_val("clr_len", n, 32'd768);
      check_val("busy_low", {31'd0, BUSY}, 32'd0);
      cpu_read(1'b1, 1'b0, 2'd0, 8'h10, rd);
      check_val("drop_wr", {16'd0, rd}, 32'd0);

      // CPU access rules.
      cpu_write(1'b1, 1'b0, 2'd1, 8'h35, 16'h001F);
      cpu_read(1'b1, 1'b0, 2'd1, 8'h35, rd);
      check_val("obj_g35", {16'd0, rd}, 32'h1F);
      cpu_write(1'b1, 1'b0, 2'd3, 8'h35, 16'h001F);
      cpu_read(1'b1, 1'b0, 2'd3, 8'h35, rd);
      check_val("comp3_rd", {16'd0, rd}, 32'd0);
      cpu_write(1'b1, 1'b1, 2'd0, 8'h35, 16'h000A);
      cpu_read(1'b1, 1'b0, 2'd0, 8'h35, rd);
      check_val("both_cs", {16'd0, rd}, 32'd0);

      cpu_write(1'b1, 1'b0, 2'd0, 8'h35, 16'hFFE3);
      cpu_write(1'b1, 1'b0, 2'd2, 8'h35, 16'h000C);
      cpu_write(1'b0, 1'b1, 2'd0, 8'h12, 16'h0011);
      cpu_write(1'b0, 1'b1, 2'd1, 8'h12, 16'h0005);
      cpu_write(1'b0, 1'b1, 2'd2, 8'h12, 16'h001A);
      cpu_read(1'b1, 1'b0, 2'd0, 8'h35, rd);
      check_val("obj_r35", {16'd0, rd}, 32'h03);
      cpu_read(1'b0, 1'b1, 2'd1, 8'h12, rd);
      check_val("bg_g12", {16'd0, rd}, 32'h05);

      // Pixel path latency and priority.
      set_pix(8'h35, 8'h00, 1'b0, 1'b0);
      ce_pulse();
      check_val("lat1", {17'd0, R, G, B}, 32'd0);
      ce_pulse();
      check_val("obj_pix", {17'd0, R, G, B}, {17'd0, OBJ_RGB});
      set_pix(8'h35, 8'h12, 1'b1, 1'b0);
      ce_pulse(); ce_pulse();
      check_val("bg_prio1", {17'd0, R, G, B}, {17'd0, BG_RGB});
      set_pix(8'h35, 8'h12, 1'b0, 1'b0);
      ce_pulse(); ce_pulse();
      check_val("bg_prio0", {17'd0, R, G, B}, {17'd0, OBJ_RGB});
      set_pix(8'h30, 8'h12, 1'b0, 1'b0);
      ce_pulse(); ce_pulse();
      check_val("obj_transp", {17'd0, R, G, B}, {17'd0, BG_RGB});
      set_pix(8'h35, 8'h12, 1'b0, 1'b1);
      ce_pulse(); ce_pulse();
      check_val("hblk", {17'd0, R, G, B}, 32'd0);
      set_pix(8'h35, 8'h12, 1'b0, 1'b0);
      ce_pulse(); ce_pulse();
      check_val("unblank", {17'd0, R, G, B}, {17'd0, OBJ_RGB});
      set_pix(8'h35, 8'h12, 1'b1, 1'b0);
      repeat (5) @(negedge CLK_32M);
      check_val("ce_hold", {17'd0, R, G, B}, {17'd0, OBJ_RGB});

      // Reset mid-run, then again mid-clear at count 400.
      RESET = 1'b1;
      @(negedge CLK_32M);
      RESET = 1'b0;
      set_pix(8'h35, 8'h00, 1'b0, 1'b0);
      CE_PIX = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if (i == 10) check_val("clr_rgb", {17'd0, R, G, B}, 32'd0);
         @(negedge CLK_32M);
      end
      check_val("mid_busy", {31'd0, BUSY}, 32'd1);
      CE_PIX = 1'b0;
      RESET = 1'b1;
      @(negedge CLK_32M);
      check_val("mid_rst_busy", {31'd0, BUSY}, 32'd1);
      RESET = 1'b0;
      n = 0;
      while (BUSY === 1'b1 && n < 2000) begin
         n++;
         @(negedge CLK_32M);
      end
      check_val("restart_len", n, 32'd768);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
